// File: rtl/usb_pkg.sv
// Shared types and constants for the USB RX bitstream front end.
package usb_pkg;

    typedef enum logic [1:0] {LS_J, LS_K, LS_SE0, LS_SE1} line_t;

    typedef enum logic [2:0] {IDLE, SYNC, DATA, EOP1, EOP2, ERR} rx_state_t;

    localparam int SYNC_ZEROS = 7;

    function automatic line_t classify(input logic dp, input logic dm);
        case ({dp, dm})
            2'b10:   return LS_J;
            2'b01:   return LS_K;
            2'b00:   return LS_SE0;
            default: return LS_SE1;
        endcase
    endfunction

endpackage

// File: rtl/usb_nrzi_dec.sv
// Line-state classification and NRZI decode against the previous J/K level.
module usb_nrzi_dec
    import usb_pkg::*;
(
    input  logic  clk,
    input  logic  rst_b,
    input  logic  dp,
    input  logic  dm,
    input  logic  load_j,
    input  logic  advance,
    output line_t line,
    output logic  dbit
);

    logic prev_k;

    assign line = classify(dp, dm);
    // A 1 is "no transition": only meaningful when line is J or K.
    assign dbit = ((line == LS_K) == prev_k);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            prev_k <= 1'b0;
        end else if (advance) begin
            prev_k <= (line == LS_K);
        end else if (load_j) begin
            prev_k <= 1'b0;
        end
    end

endmodule

// File: rtl/usb_rx_bitstream.sv
// USB RX front end: SYNC strip, NRZI decode, bit unstuffing and EOP detection,
// feeding payload bits to the packet decoder.
module usb_rx_bitstream
    import usb_pkg::*;
#(
    parameter int MAX_BITS  = 99,
    parameter int STUFF_RUN = 6,
    parameter int IDLE_J    = 2
) (
    input  logic clk,
    input  logic rst_b,
    input  logic sample_en,
    input  logic dp,
    input  logic dm,
    input  logic rx_ready_in,
    output logic bit_out,
    output logic bit_out_avail,
    output logic pkt_done,
    output logic rx_err,
    output logic rx_active
);

    localparam int JW = $clog2(IDLE_J + 1);

    rx_state_t      state, state_nxt;
    line_t          line;
    logic           dbit, is_jk, stuff_due;
    logic [2:0]     ones_cnt, zero_cnt;
    logic [6:0]     bit_cnt;
    logic [JW-1:0]  j_cnt;
    logic           fwd, drop, go_err, eop_ok;
    logic           bit_d, avail_d, done_d, err_d, active_d;

    usb_nrzi_dec u_nrzi (
        .clk     (clk),
        .rst_b   (rst_b),
        .dp      (dp),
        .dm      (dm),
        .load_j  (sample_en && state == IDLE),
        .advance (sample_en && is_jk),
        .line    (line),
        .dbit    (dbit)
    );

    assign is_jk     = (line == LS_J) || (line == LS_K);
    assign stuff_due = (ones_cnt == 3'(STUFF_RUN));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: every signal gets a default at the top of the block so no path
    // leaves it unassigned, which would infer a latch.
    always_comb begin
        state_nxt = state;
        fwd       = 1'b0;
        drop      = 1'b0;
        go_err    = 1'b0;
        eop_ok    = 1'b0;
        if (sample_en) begin
            case (state)
                IDLE: if (line == LS_K) state_nxt = SYNC;
                SYNC: begin
                    if (!is_jk)    state_nxt = IDLE;
                    else if (dbit) state_nxt = (zero_cnt == 3'(SYNC_ZEROS)) ? DATA : IDLE;
                end
                DATA: begin
                    if (is_jk) begin
                        if (stuff_due) begin
                            if (dbit) go_err = 1'b1;
                            else      drop   = 1'b1;
                        end else if (bit_cnt == 7'(MAX_BITS) || !rx_ready_in) begin
                            go_err = 1'b1;
                        end else begin
                            fwd = 1'b1;
                        end
                    end else if (line == LS_SE0 && !stuff_due) begin
                        state_nxt = EOP1;
                    end else begin
                        go_err = 1'b1;
                    end
                end
                EOP1: begin
                    if (line == LS_SE0) state_nxt = EOP2;
                    else                go_err    = 1'b1;
                end
                EOP2: begin
                    if (line == LS_J) begin
                        eop_ok    = 1'b1;
                        state_nxt = IDLE;
                    end else if (line != LS_SE0) begin
                        go_err = 1'b1;
                    end
                end
                ERR: if (line == LS_J && j_cnt == JW'(IDLE_J - 1)) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
        if (go_err) state_nxt = ERR;
    end

    // Flags are zero when sample_en is low, so pulses drop and levels hold.
    always_comb begin
        avail_d  = fwd;
        bit_d    = fwd ? dbit : bit_out;
        done_d   = go_err || eop_ok;
        err_d    = go_err;
        active_d = (state_nxt == DATA) || (state_nxt == EOP1) || (state_nxt == EOP2);
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            bit_out       <= 1'b0;
            bit_out_avail <= 1'b0;
            pkt_done      <= 1'b0;
            rx_err        <= 1'b0;
            rx_active     <= 1'b0;
        end else begin
            bit_out       <= bit_d;
            bit_out_avail <= avail_d;
            pkt_done      <= done_d;
            rx_err        <= err_d;
            rx_active     <= active_d;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            ones_cnt <= '0;
            zero_cnt <= '0;
            bit_cnt  <= '0;
            j_cnt    <= '0;
        end else if (sample_en) begin
            if (state == IDLE)
                zero_cnt <= 3'd1;
            else if (state == SYNC && is_jk && !dbit && zero_cnt != 3'(SYNC_ZEROS))
                zero_cnt <= zero_cnt + 3'd1;

            // SYNC's closing 1 is the first of the stuffing run.
            if (state == SYNC)  ones_cnt <= 3'd1;
            else if (drop)      ones_cnt <= 3'd0;
            else if (fwd)       ones_cnt <= dbit ? ones_cnt + 3'd1 : 3'd0;

            if (state == SYNC)  bit_cnt <= '0;
            else if (fwd)       bit_cnt <= bit_cnt + 7'd1;

            if (state != ERR)       j_cnt <= '0;
            else if (line == LS_J)  j_cnt <= j_cnt + JW'(1);
            else                    j_cnt <= '0;
        end
    end

endmodule
